mem_access_unit: RTL and testbench

//  Multi-cycle load/store controller directly downstream of the single-cycle datapath.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Multi-cycle load/store controller that sits behind the single-cycle datapath.
//   It takes the ALU address and store data, runs one req/gnt/rvalid bus
//   transaction, and returns the sized and extended load data. Misaligned or
//   illegal accesses are rejected in IDLE without touching the bus. A bus that
//   stops responding is cut off after TIMEOUT cycles.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   i_cpu_*          access request from the datapath (req, we, size, signed, addr, wdata)
//   o_cpu_rdata      extended load data, valid in DONE and held afterwards
//   o_cpu_stall      freezes PC/regwrite while the access is in flight
//   o_cpu_misalign   combinational reject flag in IDLE
//   o_cpu_buserr     one-cycle pulse in DONE after a timeout
//   o_mem_*          registered bus request (req, we, addr, be, wdata)
//   i_mem_*          bus response (gnt, rvalid, rdata)

module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [1:0]  i_cpu_size,
    input  logic        i_cpu_signed,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    output logic        o_cpu_misalign,
    output logic        o_cpu_buserr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req, r_mem_we;
    logic [31:0]   r_mem_addr, r_mem_wdata, r_cpu_rdata;
    logic [3:0]    r_mem_be;
    logic [1:0]    r_lane, r_size;
    logic          r_signed, r_buserr;

    logic          w_aligned, w_issue, w_capture, w_tmo, w_tmo_fire;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_shift, w_ext;

    // Alignment and bus-side encoding of the incoming request
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = i_cpu_wdata;
        case (i_cpu_size)
            2'b00: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << i_cpu_addr[1:0];
                w_wdata   = {4{i_cpu_wdata[7:0]}};
            end
            2'b01: begin
                w_aligned = ~i_cpu_addr[0];
                w_be      = 4'b0011 << {i_cpu_addr[1], 1'b0};
                w_wdata   = {2{i_cpu_wdata[15:0]}};
            end
            2'b10: begin
                w_aligned = (i_cpu_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
            end
            default: ;
        endcase
    end

    // Lane extraction: shifting the addressed lane down to bit 0 covers
    // byte, half and word (a word always has lane 0).
    always_comb begin
        w_shift = i_mem_rdata >> {r_lane, 3'b000};
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Counter value on the last allowed cycle; TIMEOUT==0 never fires
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

    always_comb begin
        w_next         = r_state;
        o_cpu_stall    = 1'b0;
        o_cpu_misalign = 1'b0;
        w_issue        = 1'b0;
        w_capture      = 1'b0;
        w_tmo_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_req) begin
                    if (w_aligned) begin
                        o_cpu_stall = 1'b1;
                        w_issue     = 1'b1;
                        w_next      = S_REQ;
                    end else begin
                        o_cpu_misalign = 1'b1;
                    end
                end
            end
            S_REQ: begin
                o_cpu_stall = 1'b1;
                if (i_mem_gnt) begin
                    if (r_mem_we) begin
                        w_next = S_DONE;
                    end else if (i_mem_rvalid) begin
                        w_capture = 1'b1;
                        w_next    = S_DONE;
                    end else begin
                        w_next = S_WAIT_R;
                    end
                end else if (w_tmo) begin
                    w_tmo_fire = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_WAIT_R: begin
                o_cpu_stall = 1'b1;
                if (i_mem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (w_tmo) begin
                    w_tmo_fire = 1'b1;
                    w_next     = S_DONE;
                end
            end
            // Unconditional exit so the same instruction is never reissued
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_lane      <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_buserr    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_buserr <= w_tmo_fire;
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= i_cpu_we;
                r_mem_addr  <= {i_cpu_addr[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
                r_lane      <= i_cpu_addr[1:0];
                r_size      <= i_cpu_size;
                r_signed    <= i_cpu_signed;
                r_cnt       <= '0;
            end else if (r_state == S_REQ || r_state == S_WAIT_R) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Request is held until accepted or abandoned by timeout
            if (r_state == S_REQ && w_next != S_REQ)
                r_mem_req <= 1'b0;
            if (w_capture)
                r_cpu_rdata <= w_ext;
            else if (w_tmo_fire)
                r_cpu_rdata <= '0;
        end
    end

    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_cpu_buserr = r_buserr;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_be     = r_mem_be;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_signed;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_misalign, cpu_buserr;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_size(cpu_size),
        .i_cpu_signed(cpu_signed), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .o_cpu_misalign(cpu_misalign), .o_cpu_buserr(cpu_buserr),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr, wd, rd;
        int          gd, rvd;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr, exp_wd, exp_rd;
        int          exp_nst;
    } vec_t;

    vec_t vecs[$];

    // Observations from the last run_acc call
    int          o_nst, o_nreq, o_done_c;
    logic        o_mis, o_berr, o_stable, o_done, o_saw_req, o_we;
    logic [31:0] o_rd, o_addr, o_wd;
    logic [3:0]  o_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drives one access; the bus grants on REQ cycle gd and returns read
    // data rvd cycles after the grant. Counts stall cycles until DONE.
    task automatic run_acc(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rvd, input int budget);
        int gc;
        logic granted;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_signed = sg;
        cpu_addr = a; cpu_wdata = wd; mem_rdata = rd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        o_mis = cpu_misalign; o_nst = 0; o_nreq = 0; o_stable = 1'b1; o_done = 1'b0;
        o_berr = 1'b0; o_rd = '0; o_done_c = -1; o_saw_req = 1'b0;
        granted = 1'b0; gc = 0;
        if (cpu_stall) begin
            o_nst = 1;
            for (int c = 0; c < budget && !o_done; c++) begin
                @(negedge clk);
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                if (mem_req) begin
                    if (o_nreq == 0) begin
                        o_addr = mem_addr; o_be = mem_be; o_wd = mem_wdata; o_we = mem_we;
                    end else if (mem_addr !== o_addr || mem_be !== o_be ||
                                 mem_wdata !== o_wd || mem_we !== o_we) begin
                        o_stable = 1'b0;
                    end
                    if (o_nreq == gd) begin
                        mem_gnt = 1'b1; granted = 1'b1; gc = c;
                    end
                    o_nreq++;
                end
                if (!we && granted && c == gc + rvd) mem_rvalid = 1'b1;
                #1;
                if (cpu_stall) o_nst++;
                else begin
                    o_done = 1'b1; o_done_c = c; o_rd = cpu_rdata; o_berr = cpu_buserr;
                end
            end
        end else begin
            @(negedge clk);
            #1;
            o_saw_req = mem_req;
            o_done = 1'b1;
        end
        @(negedge clk);
        cpu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        //            name        we  sz    sg  addr          wd            rd            gd rvd mis be      addr          wd            rd            nst
        vecs.push_back('{"sw",     1, 2'b10, 0, 32'h10010004, 32'h11223344, 32'h0,        0, 1, 0, 4'b1111, 32'h10010004, 32'h11223344, 32'h0,        2});
        vecs.push_back('{"lb",     0, 2'b00, 1, 32'h10010003, 32'h0,        32'h80FF0000, 0, 1, 0, 4'b1000, 32'h10010000, 32'h0,        32'hFFFFFF80, 3});
        vecs.push_back('{"lbu",    0, 2'b00, 0, 32'h10010003, 32'h0,        32'h80FF0000, 0, 1, 0, 4'b1000, 32'h10010000, 32'h0,        32'h00000080, 3});
        vecs.push_back('{"sh",     1, 2'b01, 0, 32'h10010002, 32'h0000BEEF, 32'h0,        0, 1, 0, 4'b1100, 32'h10010000, 32'hBEEFBEEF, 32'h0,        2});
        vecs.push_back('{"lh_mis", 0, 2'b01, 1, 32'h10010001, 32'h0,        32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{"sb",     1, 2'b00, 0, 32'h10010001, 32'h000000A5, 32'h0,        0, 1, 0, 4'b0010, 32'h10010000, 32'hA5A5A5A5, 32'h0,        2});
        vecs.push_back('{"lh_hi",  0, 2'b01, 1, 32'h10010002, 32'h0,        32'h80FF1234, 0, 1, 0, 4'b1100, 32'h10010000, 32'h0,        32'hFFFF80FF, 3});
        vecs.push_back('{"lhu_lo", 0, 2'b01, 0, 32'h10010000, 32'h0,        32'h80FF9234, 0, 1, 0, 4'b0011, 32'h10010000, 32'h0,        32'h00009234, 3});
        vecs.push_back('{"lh_lo",  0, 2'b01, 1, 32'h10010000, 32'h0,        32'h80FF9234, 0, 1, 0, 4'b0011, 32'h10010000, 32'h0,        32'hFFFF9234, 3});
        vecs.push_back('{"lw",     0, 2'b10, 0, 32'h10010008, 32'h0,        32'hDEADBEEF, 0, 1, 0, 4'b1111, 32'h10010008, 32'h0,        32'hDEADBEEF, 3});
        vecs.push_back('{"sw_mis", 1, 2'b10, 0, 32'h10010002, 32'h12345678, 32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{"sz11",   0, 2'b11, 0, 32'h10010000, 32'h0,        32'h0,        0, 1, 1, 4'b0000, 32'h0,        32'h0,        32'h0,        0});
        vecs.push_back('{"lbu0",   0, 2'b00, 0, 32'h10010000, 32'h0,        32'h80FF1234, 0, 1, 0, 4'b0001, 32'h10010000, 32'h0,        32'h00000034, 3});
        vecs.push_back('{"sw_gd3", 1, 2'b10, 0, 32'h1001000C, 32'hA0B0C0D0, 32'h0,        3, 1, 0, 4'b1111, 32'h1001000C, 32'hA0B0C0D0, 32'h0,        5});
        vecs.push_back('{"lw_gd3", 0, 2'b10, 0, 32'h10010010, 32'h0,        32'h01020304, 3, 2, 0, 4'b1111, 32'h10010010, 32'h0,        32'h01020304, 7});
        vecs.push_back('{"sw_g15", 1, 2'b10, 0, 32'h10010014, 32'h55AA55AA, 32'h0,       15, 1, 0, 4'b1111, 32'h10010014, 32'h55AA55AA, 32'h0,       17});
        vecs.push_back('{"lw_gr0", 0, 2'b10, 0, 32'h10010018, 32'h0,        32'hCAFEF00D, 0, 0, 0, 4'b1111, 32'h10010018, 32'h0,        32'hCAFEF00D, 2});

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_flags", {29'b0, cpu_stall, cpu_misalign, cpu_buserr}, 32'h0);
        // Stale rvalid after reset must not load anything
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rst_stale_rdata", cpu_rdata, 32'h0);

        foreach (vecs[i]) begin
            run_acc(vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd,
                    vecs[i].rd, vecs[i].gd, vecs[i].rvd, 40);
            chk({vecs[i].name, "_misalign"}, {31'b0, o_mis}, {31'b0, vecs[i].exp_mis});
            chk({vecs[i].name, "_nstall"}, o_nst, vecs[i].exp_nst);
            if (!o_done) chk({vecs[i].name, "_done_wait"}, 32'h0, 32'h1);
            if (vecs[i].exp_mis) begin
                chk({vecs[i].name, "_no_req"}, {31'b0, o_saw_req}, 32'h0);
            end else begin
                chk({vecs[i].name, "_nreq"}, o_nreq, vecs[i].gd + 1);
                chk({vecs[i].name, "_addr"}, o_addr, vecs[i].exp_addr);
                chk({vecs[i].name, "_be"}, {28'b0, o_be}, {28'b0, vecs[i].exp_be});
                chk({vecs[i].name, "_we"}, {31'b0, o_we}, {31'b0, vecs[i].we});
                chk({vecs[i].name, "_stable"}, {31'b0, o_stable}, 32'h1);
                chk({vecs[i].name, "_buserr"}, {31'b0, o_berr}, 32'h0);
                if (vecs[i].we) chk({vecs[i].name, "_wdata"}, o_wd, vecs[i].exp_wd);
                else            chk({vecs[i].name, "_rdata"}, o_rd, vecs[i].exp_rd);
            end
        end

        // Load never granted: bus error 16 cycles after entering REQ
        run_acc(1'b0, 2'b10, 1'b0, 32'h10010020, 32'h0, 32'h0, 1000, 1000, 40);
        chk("tmo_gnt_done_c", o_done_c, 16);
        chk("tmo_gnt_nreq", o_nreq, 16);
        chk("tmo_gnt_buserr", {31'b0, o_berr}, 32'h1);
        chk("tmo_gnt_rdata", o_rd, 32'h0);
        #1;
        chk("tmo_gnt_idle", {30'b0, cpu_buserr, mem_req}, 32'h0);
        chk("tmo_gnt_stall", {31'b0, cpu_stall}, 32'h0);

        // Granted load whose data never returns times out in WAIT_R
        run_acc(1'b0, 2'b10, 1'b0, 32'h10010024, 32'h0, 32'h0, 0, 1000, 40);
        chk("tmo_rv_done_c", o_done_c, 16);
        chk("tmo_rv_buserr", {31'b0, o_berr}, 32'h1);

        // Reset in WAIT_R, then a late rvalid
        run_acc(1'b0, 2'b10, 1'b0, 32'h10010028, 32'h0, 32'h76543210, 0, 1, 40);
        chk("pre_rst_rdata", o_rd, 32'h76543210);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h1001002C;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        cpu_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("wait_r_stall", {31'b0, cpu_stall}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_rvalid = 1'b1;
        #1;
        chk("rst_mid_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mid_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_mid_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rst_rv_ign_rdata", cpu_rdata, 32'h0);
        chk("rst_rv_ign_flags", {30'b0, cpu_stall, mem_req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
